// File: rtl/clk_div_pkg.sv
// Shared constants, state encoding and divisor helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEFAULT   = 16;
    localparam int unsigned DIV_DEFAULT     = 50;  // 50 MHz -> 1 MHz
    localparam int unsigned MIN_DIV_DEFAULT = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Requests below the smallest legal divisor are raised to it, so 0 and 1 never stall the counter.
    function automatic logic [31:0] clamp_div(input logic [31:0] d, input logic [31:0] min_d);
        return (d < min_d) ? min_d : d;
    endfunction

    // Low-phase length: odd divisors put the extra cycle in the low phase.
    function automatic logic [31:0] low_len(input logic [31:0] d);
        return d - (d >> 1);
    endfunction

endpackage

// File: rtl/clk_div_if.sv
// Control/status bundle between a bus master and the programmable clock divider.
interface clk_div_if
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
);
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             div_ack;
    logic             clk_out;
    logic             rise_stb;
    logic             fall_stb;
    logic             idle;
    logic [CNT_W-1:0] cur_div;

    modport master (
        output en, div_val, div_load,
        input  div_ack, clk_out, rise_stb, fall_stb, idle, cur_div
    );

    modport slave (
        input  en, div_val, div_load,
        output div_ack, clk_out, rise_stb, fall_stb, idle, cur_div
    );
endinterface

// File: rtl/clk_div_core.sv
// Phase counter plus registered clk_out and edge strobes for the active divisor.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             stop_at_wrap,
    input  logic [CNT_W-1:0] cur_div,
    output logic             wrap,
    output logic             stop_now,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             fall_stb
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_m1;
    logic [CNT_W-1:0] low_m1;

    // Both compare points derive from the active divisor only, never from a pending one.
    assign div_m1   = cur_div - CNT_W'(1);
    assign low_m1   = CNT_W'(low_len(32'(cur_div)) - 32'd1);
    assign wrap     = run && (cnt_q == div_m1);
    assign stop_now = wrap && stop_at_wrap;

    // Count through the period; raise clk_out after the low phase and drop it at the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            clk_out  <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register in this block sees pre-edge values.
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            if (!run) begin
                cnt_q   <= '0;
                clk_out <= 1'b0;
            end else if (wrap) begin
                cnt_q    <= '0;
                clk_out  <= 1'b0;
                fall_stb <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == low_m1) begin
                    clk_out  <= 1'b1;
                    rise_stb <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: run/stop FSM, divisor pending register and load acknowledge.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned DEF_DIV = DIV_DEFAULT,
    parameter int unsigned MIN_DIV = MIN_DIV_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    clk_div_if.slave  bus
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cur_div_q;
    logic [CNT_W-1:0] pend_q;
    logic             pend_vld_q;
    logic             ack_q;
    logic             idle_q;
    logic [CNT_W-1:0] load_val;
    logic             apply_now;
    logic [CNT_W-1:0] apply_val;
    logic             wrap;
    logic             stop_now;
    logic             clk_out;
    logic             rise_stb;
    logic             fall_stb;

    assign load_val = CNT_W'(clamp_div(32'(bus.div_val), MIN_DIV));

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (state_q == RUN),
        .stop_at_wrap (!bus.en),
        .cur_div      (cur_div_q),
        .wrap         (wrap),
        .stop_now     (stop_now),
        .clk_out      (clk_out),
        .rise_stb     (rise_stb),
        .fall_stb     (fall_stb)
    );

    // Next state, and which divisor (if any) becomes active at this edge.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d   = state_q;
        apply_now = 1'b0;
        apply_val = pend_q;

        case (state_q)
            IDLE:    if (bus.en)  state_d = RUN;
            RUN:     if (stop_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A load coinciding with the wrap goes straight into the following period.
        if (wrap && bus.div_load) begin
            apply_now = 1'b1;
            apply_val = load_val;
        end else if (pend_vld_q && (wrap || state_q == IDLE)) begin
            apply_now = 1'b1;
        end
    end

    // State register, active divisor, pending divisor and the status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_div_q  <= CNT_W'(DEF_DIV);
            pend_q     <= CNT_W'(DEF_DIV);
            pend_vld_q <= 1'b0;
            ack_q      <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            // idle drops as soon as a run starts but rises one cycle after the final fall.
            idle_q  <= (state_q == IDLE) && (state_d == IDLE);
            ack_q   <= apply_now;
            if (apply_now) begin
                cur_div_q <= apply_val;
            end
            if (bus.div_load && !wrap) begin
                pend_q     <= load_val;
                pend_vld_q <= 1'b1;
            end else if (apply_now) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    assign bus.div_ack  = ack_q;
    assign bus.clk_out  = clk_out;
    assign bus.rise_stb = rise_stb;
    assign bus.fall_stb = fall_stb;
    assign bus.idle     = idle_q;
    assign bus.cur_div  = cur_div_q;

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Programmable successor to the fixed 1 MHz divider.
- Divides the system clock `clk` by a runtime-selectable ratio D and produces a near-50% duty divided clock `clk_out`.
- Also produces one-cycle `rise_stb`/`fall_stb` strobes in the `clk` domain, so the OLED SPI/I2C bit engines can run on enables instead of a derived clock.
- Supports glitch-free ratio changes at period boundaries and a clean start/stop via `en`.

Parameters:
- CNT_W, 16, width of divisor and phase counter.
- DEF_DIV, 50, divisor after reset (50 MHz -> 1 MHz).
- MIN_DIV, 2, smallest legal divisor; smaller requests are clamped to it.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run request; 1 = run, 0 = stop at end of current period
- div_val  in  CNT_W  requested divisor D
- div_load  in  1  single-cycle request to adopt div_val
- div_ack  out  1  one-cycle pulse: the new divisor has become active
- clk_out  out  1  divided clock, registered
- rise_stb  out  1  one-cycle pulse in the cycle clk_out becomes 1
- fall_stb  out  1  one-cycle pulse in the cycle clk_out becomes 0
- idle  out  1  1 when stopped (clk_out low, counter parked)
- cur_div  out  CNT_W  currently active divisor

Behaviour:
- Reset (rst_n=0, async): cnt=0, cur_div=DEF_DIV, pending cleared, clk_out=0, strobes=0, div_ack=0, idle=1.
- Phase timing:
  - Low phase L = D - floor(D/2) cycles, high phase H = floor(D/2) cycles, period D cycles.
  - Odd D gives one extra low cycle. Example: D=5 gives 3 low, 2 high.
- Counter:
  - cnt runs 0..D-1 while running.
  - When cnt==L-1: next cycle clk_out=1 and rise_stb=1.
  - When cnt==D-1 (wrap): next cycle clk_out=0, fall_stb=1, cnt=0.
  - Strobes are registered and coincide with the clk_out edge.
- States: IDLE and RUN.
  - IDLE -> RUN on a cycle sampling en=1. Next cycle cnt=0, idle=0. First rise_stb occurs L+1 cycles after the sampling edge.
  - RUN -> IDLE at a wrap where en=0: clk_out goes 0 with fall_stb, then idle=1 next cycle. A partial period is never truncated.
  - en re-asserted before the wrap: no stop occurs, and the output is uninterrupted.
- Divisor load:
  - div_load captures clamp(div_val) into a pending register and sets pending.
  - The pending value is applied at the next wrap, or on the next cycle if in IDLE.
  - When applied: cur_div updates, pending clears, and div_ack pulses 1 cycle, aligned with the first cycle of the new period.
  - Repeated loads before application: the last value wins, with exactly one div_ack.
  - div_load in the same cycle as a wrap: that div_val applies to the immediately following period.
  - Clamp: div_val < MIN_DIV is treated as MIN_DIV. Values 0 and 1 never stall the counter.
- D=2: 1 low, 1 high. clk_out toggles every cycle; rise_stb and fall_stb alternate.
- Reset mid-period: immediate async return to reset values. No strobe is emitted on reset.
- Arithmetic: cnt and the comparisons are CNT_W bits unsigned. L is computed from cur_div only, never from pending.

Decomposition:
- Package clk_div_pkg holds:
  - CNT_W, DEF_DIV, MIN_DIV defaults
  - a clamp_div function
  - a low_len function (D - D/2)
  - the state encoding IDLE/RUN
- Sub-module clk_div_core: phase counter plus clk_out/strobe generation from cur_div, run and stop_at_wrap.
- clk_div_prog owns the state machine, pending register, clamp and div_ack.

Test Plan:
- Reset, then en=1 with DEF_DIV=50 -> clk_out period 50, 25 low/25 high; first rise_stb 26 cycles after en is sampled; one rise_stb and one fall_stb per period.
- div_val=5 loaded while idle -> div_ack next cycle, cur_div=5; running then gives a 3-low/2-high pattern repeating every 5 cycles.
- Running at D=10: load 4 at cnt=3, then 6 at cnt=7 -> single div_ack at the wrap; next period is 6 cycles (3/3); no runt pulse.
- div_val=0 and div_val=1 -> cur_div=2; clk_out toggles every cycle; strobes alternate.
- en dropped at cnt=2 of a D=8 period -> high phase completes, fall_stb at the wrap, idle=1 next cycle, clk_out stays 0.
- rst_n pulsed low while clk_out=1 -> clk_out=0, cur_div=50, idle=1 asynchronously; no strobe is emitted.
